// File: rtl/pingpong_frame_writer_if.sv
// Bundles the source byte stream, the two RAM-bank write ports and the
// reader-side frame handshake of the ping-pong frame writer.
// The slave modport is the writer's view; the master modport is the view of
// whatever surrounds it (source, RAMs and reader together).
interface pingpong_frame_writer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  // Source stream
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  // Bank 1 write port
  logic              ram1_write_en;
  logic [ADDR_W-1:0] ram1_write_address;
  logic [DATA_W-1:0] ram1_write_data;

  // Bank 2 write port
  logic              ram2_write_en;
  logic [ADDR_W-1:0] ram2_write_address;
  logic [DATA_W-1:0] ram2_write_data;

  // Reader handshake and status
  logic              frame_valid;
  logic              front_bank;
  logic              frame_done;
  logic [7:0]        frame_count;

  modport slave (
    input  in_valid, in_data, frame_done,
    output in_ready,
    output ram1_write_en, ram1_write_address, ram1_write_data,
    output ram2_write_en, ram2_write_address, ram2_write_data,
    output frame_valid, front_bank, frame_count
  );

  modport master (
    output in_valid, in_data, frame_done,
    input  in_ready,
    input  ram1_write_en, ram1_write_address, ram1_write_data,
    input  ram2_write_en, ram2_write_address, ram2_write_data,
    input  frame_valid, front_bank, frame_count
  );
endinterface

// File: rtl/pingpong_frame_writer.sv
// Write side of the beat-map double buffer. Packs the incoming byte stream
// into DEPTH-byte frames and writes them alternately into two external RAM
// banks through a one-deep registered write stage. A bank becomes "full"
// once its last byte has been committed and stays full until the reader
// releases it with frame_done; the writer stalls rather than overwrite it.
module pingpong_frame_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  pingpong_frame_writer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Write pointer: bank currently being filled and next byte address in it
  logic              r_wr_bank;
  logic [ADDR_W-1:0] r_wr_addr;

  // Staged-write bookkeeping shared by both banks
  logic              r_stg_last;
  logic              r_stg_bank;

  // Reader side
  logic              r_front_bank;
  logic [7:0]        r_frame_count;

  // Per-bank signals collected from the generate loop
  logic [1:0]        w_full;
  logic [1:0]        w_bank_we;
  logic [ADDR_W-1:0] w_bank_addr [2];
  logic [DATA_W-1:0] w_bank_data [2];

  logic              w_in_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_commit;
  logic              w_release;

  // Ready comes from registers only, so the source may look at it freely.
  assign w_in_ready = !w_full[r_wr_bank];
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last     = (r_wr_addr == LAST_ADDR);
  // The last byte of a frame is committed by the RAM at the edge that ends
  // its strobe; that edge is when the bank counts as holding a frame.
  assign w_commit   = (|w_bank_we) && r_stg_last;
  // Release looks at the pre-edge full flags, so a bank that is only being
  // marked full at this edge can never be released by the same edge.
  assign w_release  = bus.frame_done && w_full[r_front_bank];

  // Advance the write pointer on every accepted byte, switching bank at wrap
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_bank <= 1'b0;
      r_wr_addr <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_wr_addr <= '0;
        r_wr_bank <= !r_wr_bank;
      end else begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end
    end
  end

  // Remember which bank the staged byte targets and whether it closes a frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stg_last <= 1'b0;
      r_stg_bank <= 1'b0;
    end else begin
      r_stg_last <= w_accept && w_last;
      if (w_accept) begin
        r_stg_bank <= r_wr_bank;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic              w_sel;
      logic              r_we;
      logic [ADDR_W-1:0] r_addr;
      logic [DATA_W-1:0] r_data;
      logic              r_full;

      assign w_sel = (r_wr_bank == 1'(gi));

      // Write stage: strobe this bank for one cycle after an accepted byte;
      // address and data hold their last value while the bank is idle.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_we   <= 1'b0;
          r_addr <= '0;
          r_data <= '0;
        end else begin
          r_we <= w_accept && w_sel;
          if (w_accept && w_sel) begin
            r_addr <= r_wr_addr;
            r_data <= bus.in_data;
          end
        end
      end

      // Full flag: set when this bank's last byte commits, cleared on release
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_full <= 1'b0;
        end else if (w_commit && (r_stg_bank == 1'(gi))) begin
          r_full <= 1'b1;
        end else if (w_release && (r_front_bank == 1'(gi))) begin
          r_full <= 1'b0;
        end
      end

      assign w_full[gi]      = r_full;
      assign w_bank_we[gi]   = r_we;
      assign w_bank_addr[gi] = r_addr;
      assign w_bank_data[gi] = r_data;
    end
  endgenerate

  // Hand the reader the other bank each time it finishes with the front one
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_front_bank <= 1'b0;
    end else if (w_release) begin
      r_front_bank <= !r_front_bank;
    end
  end

  // Count completed frames, wrapping naturally at 256
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_count <= 8'd0;
    end else if (w_commit) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign bus.in_ready           = w_in_ready;
  assign bus.ram1_write_en      = w_bank_we[0];
  assign bus.ram1_write_address = w_bank_addr[0];
  assign bus.ram1_write_data    = w_bank_data[0];
  assign bus.ram2_write_en      = w_bank_we[1];
  assign bus.ram2_write_address = w_bank_addr[1];
  assign bus.ram2_write_data    = w_bank_data[1];
  assign bus.frame_valid        = w_full[r_front_bank];
  assign bus.front_bank         = r_front_bank;
  assign bus.frame_count        = r_frame_count;

endmodule
